synchronous_fifo: RTL and testbench

Single-clock first-in/first-out buffer of DEPTH entries, each WIDTH bits wide. Write and read share one clock. Status flags full and empty gate producer and consumer. It serves as a general-purpose rate/ordering buffer between two blocks in the same clock domain.

---
 rtl/synchronous_fifo_mem.sv | 38 +++
 rtl/synchronous_fifo.sv | 63 ++++++
 tb/tb_synchronous_fifo.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/synchronous_fifo_mem.sv
// Storage array for synchronous_fifo.
// One write port and one registered read port. The read register is reset
// so that dout starts at zero and never shows uninitialised storage.
module synchronous_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage write; contents are left alone on reset because they are
    // unreachable until rewritten.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read data; holds its value when no read is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/synchronous_fifo.sv
// Single-clock FIFO: pointers, status flags and accept logic.
// Pointers carry one extra wrap bit so full and empty can be told apart
// when the index bits are equal.
module synchronous_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        wr_acc;
    logic        rd_acc;

    // Flags come straight from the registered pointers, so they reflect an
    // accepted transfer in the cycle right after its edge.
    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    // Requests that would overflow or underflow are silently dropped.
    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    // Pointer advance; natural binary rollover gives modulo-DEPTH indexing
    // with the MSB toggling once per lap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    synchronous_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_acc),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (data),
        .re    (rd_acc),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (dout)
    );

endmodule

// File: tb/tb_synchronous_fifo.sv
// Self-checking bench for synchronous_fifo: reset checks, a vector table
// for fill/drain, hand sequences for corner cases, then random traffic
// against a queue-based reference model.
module tb_synchronous_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             wr_en = 1'b0;
    logic             rd_en = 1'b0;
    logic [WIDTH-1:0] data = '0;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             empty;

    int tests = 0;
    int fails = 0;

    // reference model
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_dout = '0;

    typedef struct {
        logic             wr;
        logic             rd;
        logic [WIDTH-1:0] d;
        logic [WIDTH-1:0] exp_dout;
        logic             exp_full;
        logic             exp_empty;
    } vec_t;

    vec_t tbl[16];

    synchronous_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .wr_en (wr_en),
        .rd_en (rd_en),
        .data  (data),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Apply one cycle of stimulus, advance the model, and compare DUT
    // outputs to the model one time unit after the edge.
    task automatic drive(input logic wr, input logic rd, input logic [WIDTH-1:0] d);
        bit wa, ra;
        @(negedge clk);
        wr_en = wr; rd_en = rd; data = d;
        wa = wr && (q.size() < DEPTH);
        ra = rd && (q.size() > 0);
        @(posedge clk);
        if (ra) m_dout = q.pop_front();
        if (wa) q.push_back(d);
        #1;
        chk("model_dout",  int'(dout),  int'(m_dout));
        chk("model_full",  int'(full),  int'(q.size() == DEPTH));
        chk("model_empty", int'(empty), int'(q.size() == 0));
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; rd_en = 1'b0; data = '0;
    endtask

    initial begin
        // table: fill with 0..7 then drain
        for (int i = 0; i < 8; i++) begin
            tbl[i] = '{1'b1, 1'b0, 8'(i), 8'd0, (i == 7), 1'b0};
            tbl[8+i] = '{1'b0, 1'b1, 8'd0, 8'(i), 1'b0, (i == 7)};
        end

        // reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_empty", int'(empty), 1);
        chk("rst_full",  int'(full),  0);
        chk("rst_dout",  int'(dout),  0);

        // fill then drain from the vector table
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].wr, tbl[i].rd, tbl[i].d);
            chk($sformatf("tbl%0d_dout", i),  int'(dout),  int'(tbl[i].exp_dout));
            chk($sformatf("tbl%0d_full", i),  int'(full),  int'(tbl[i].exp_full));
            chk($sformatf("tbl%0d_empty", i), int'(empty), int'(tbl[i].exp_empty));
        end

        // underflow: dout holds 7
        repeat (2) begin
            drive(1'b0, 1'b1, 8'h00);
            chk("uflow_dout",  int'(dout),  7);
            chk("uflow_empty", int'(empty), 1);
        end

        // overflow: 0xAA dropped
        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 8'(i));
        drive(1'b1, 1'b0, 8'hAA);
        chk("oflow_full", int'(full), 1);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            chk("oflow_dout", int'(dout), i);
        end
        chk("oflow_empty", int'(empty), 1);

        // wrap-around reuse
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'(100 + i));
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            chk("wrap_dout", int'(dout), 100 + i);
        end
        chk("wrap_empty", int'(empty), 1);

        // simultaneous read/write with 4 entries stored
        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 8'(10 + i));
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 8'(20 + i));
            chk("sim_dout",  int'(dout),  10 + i);
            chk("sim_full",  int'(full),  0);
            chk("sim_empty", int'(empty), 0);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            chk("sim_drain", int'(dout), 20 + i);
        end
        chk("sim_end_empty", int'(empty), 1);

        // simultaneous on empty: write only, no bypass
        drive(1'b1, 1'b1, 8'h5A);
        chk("we_empty_dout",  int'(dout),  23);
        chk("we_empty_empty", int'(empty), 0);
        drive(1'b0, 1'b1, 8'h00);
        chk("we_empty_read",  int'(dout),  8'h5A);

        // async reset with 3 entries stored, checked between clock edges
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 8'(30 + i));
        idle_inputs();
        #1;
        rst = 1'b1;
        #1;
        chk("arst_empty", int'(empty), 1);
        chk("arst_full",  int'(full),  0);
        chk("arst_dout",  int'(dout),  0);
        #1;
        rst = 1'b0;
        q.delete();
        m_dout = '0;

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
